// File: rtl/framebuffer_pkg.sv
// Framebuffer shared types: controller state encoding and address-width helper.
// No logic; types and constants only.
// Imported by framebuffer_pixel_source.
package framebuffer_pkg;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } fb_state_t;

    // Bits needed to address a w*h one-bit-per-pixel frame (at least 1).
    function automatic int fb_addr_w(input int w, input int h);
        return (w * h > 1) ? $clog2(w * h) : 1;
    endfunction

    // Address width of the default 240x320 panel.
    localparam int FB_ADDR_W = fb_addr_w(240, 320);

endpackage

// File: rtl/ili9341_pkg.sv
// Shared ILI9341 display definitions: RGB565 colour type and common colour constants.
// No logic; types and constants only.
// Imported by any block that produces pixels for the ILI9341 panel.
package ili9341_pkg;

    typedef logic [15:0] ILI9341_color_t;

    localparam ILI9341_color_t BLACK = 16'h0000;
    localparam ILI9341_color_t WHITE = 16'hFFFF;
    localparam ILI9341_color_t RED   = 16'hF800;
    localparam ILI9341_color_t GREEN = 16'h07E0;
    localparam ILI9341_color_t BLUE  = 16'h001F;

endpackage

// File: rtl/simple_dual_port_ram.sv
// Purpose: one write port, one read port RAM, read-first on same-address collisions.
// Latency: 1 cycle registered read (rdata updates on the edge where re is high).
// Backpressure: none; accepts one write and one read every cycle.
// Ports: clk; we/waddr/wdata write port; re/raddr/rdata read port.
module simple_dual_port_ram #(
    parameter int W  = 1,
    parameter int L  = 2,
    localparam int AW = (L > 1) ? $clog2(L) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [L];

    // Both updates are non-blocking in one block, so a read of the address
    // being written in the same cycle returns the previous contents.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/framebuffer_pixel_source.sv
// Purpose: 1-bit-per-pixel framebuffer; accepts draw requests and streams raster-order RGB565 pixels.
// Latency: draw writes 1 cycle after acceptance; pixel_valid rises 2 cycles after entering run or after an advance.
// Backpressure: draw_ready low while clearing; raster only moves on pixel_advance while pixel_valid is high.
//
// Ports: clk, rstb (async active-low), ena (global clock enable);
//        draw_valid/draw_ready/draw_x/draw_y/draw_ink draw request, draw_err out-of-range pulse;
//        clear_req full-frame erase, busy while clearing;
//        pixel_advance/pixel_valid/pixel_color raster output.
// Optional feature macro FRAMEBUFFER_CURSOR_EN: overlays CURSOR_COLOR at the last drawn position.
module framebuffer_pixel_source
    import ili9341_pkg::*;
    import framebuffer_pkg::*;
#(
    parameter int             DISPLAY_WIDTH  = 240,
    parameter int             DISPLAY_HEIGHT = 320,
    parameter ILI9341_color_t FG_COLOR       = WHITE,
    parameter ILI9341_color_t BG_COLOR       = BLACK
`ifdef FRAMEBUFFER_CURSOR_EN
    ,
    parameter ILI9341_color_t CURSOR_COLOR   = RED
`endif
) (
    input  logic                              clk,
    input  logic                              rstb,
    input  logic                              ena,
    input  logic                              draw_valid,
    output logic                              draw_ready,
    input  logic [$clog2(DISPLAY_WIDTH)-1:0]  draw_x,
    input  logic [$clog2(DISPLAY_HEIGHT)-1:0] draw_y,
    input  logic                              draw_ink,
    output logic                              draw_err,
    input  logic                              clear_req,
    output logic                              busy,
    input  logic                              pixel_advance,
    output logic                              pixel_valid,
    output ILI9341_color_t                    pixel_color
);

    localparam int NPIX   = DISPLAY_WIDTH * DISPLAY_HEIGHT;
    localparam int ADDR_W = fb_addr_w(DISPLAY_WIDTH, DISPLAY_HEIGHT);
    localparam int XW     = $clog2(DISPLAY_WIDTH);
    localparam int YW     = $clog2(DISPLAY_HEIGHT);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);
    localparam logic [XW-1:0]     LAST_X    = XW'(DISPLAY_WIDTH - 1);
    localparam logic [YW-1:0]     LAST_Y    = YW'(DISPLAY_HEIGHT - 1);

    fb_state_t         state;
    logic [ADDR_W-1:0] clr_addr;
    logic [XW-1:0]     rd_x;
    logic [YW-1:0]     rd_y;
    logic              wr_pend;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_bit;
    // fetch_a: raster address is new, RAM samples it next edge.
    // fetch_b: RAM output now holds that pixel, load the colour next edge.
    logic              fetch_a;
    logic              fetch_b;

    logic              draw_acc;
    logic              draw_in_range;
    logic [ADDR_W-1:0] draw_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic              ram_wdata;
    logic [0:0]        ram_rdata;
    ILI9341_color_t    color_next;

    assign draw_acc      = draw_valid && draw_ready;
    assign draw_in_range = (32'(draw_x) < DISPLAY_WIDTH) && (32'(draw_y) < DISPLAY_HEIGHT);
    assign draw_addr     = ADDR_W'(draw_y) * ADDR_W'(DISPLAY_WIDTH) + ADDR_W'(draw_x);
    assign rd_addr       = ADDR_W'(rd_y) * ADDR_W'(DISPLAY_WIDTH) + ADDR_W'(rd_x);

    // The clear sweep owns the write port; a draw left pending when a clear
    // starts is dropped since the sweep erases that address anyway.
    assign ram_we    = ena && ((state == S_CLEAR) || wr_pend);
    assign ram_waddr = (state == S_CLEAR) ? clr_addr : wr_addr;
    assign ram_wdata = (state == S_CLEAR) ? 1'b0 : wr_bit;

    simple_dual_port_ram #(
        .W (1),
        .L (NPIX)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ena),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

`ifdef FRAMEBUFFER_CURSOR_EN
    logic [XW-1:0] cursor_x;
    logic [YW-1:0] cursor_y;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cursor_x <= '0;
            cursor_y <= '0;
        end else if (ena && draw_acc && draw_in_range) begin
            cursor_x <= draw_x;
            cursor_y <= draw_y;
        end
    end

    always_comb begin
        color_next = ram_rdata[0] ? FG_COLOR : BG_COLOR;
        if ((rd_x == cursor_x) && (rd_y == cursor_y)) begin
            color_next = CURSOR_COLOR;
        end
    end
`else
    always_comb begin
        color_next = ram_rdata[0] ? FG_COLOR : BG_COLOR;
    end
`endif

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state       <= S_CLEAR;
            clr_addr    <= '0;
            rd_x        <= '0;
            rd_y        <= '0;
            draw_ready  <= 1'b0;
            draw_err    <= 1'b0;
            busy        <= 1'b1;
            pixel_valid <= 1'b0;
            pixel_color <= BG_COLOR;
            wr_pend     <= 1'b0;
            wr_addr     <= '0;
            wr_bit      <= 1'b0;
            fetch_a     <= 1'b0;
            fetch_b     <= 1'b0;
        end else if (ena) begin
            draw_err <= 1'b0;
            wr_pend  <= 1'b0;
            fetch_a  <= 1'b0;
            fetch_b  <= fetch_a;

            // Handshake already completed whenever draw_ready was high.
            if (draw_acc) begin
                if (draw_in_range) begin
                    wr_pend <= 1'b1;
                    wr_addr <= draw_addr;
                    wr_bit  <= draw_ink;
                end else begin
                    draw_err <= 1'b1;
                end
            end

            case (state)
                S_CLEAR: begin
                    if (clear_req) begin
                        clr_addr <= '0;
                    end else if (clr_addr == LAST_ADDR) begin
                        state      <= S_RUN;
                        busy       <= 1'b0;
                        draw_ready <= 1'b1;
                        fetch_a    <= 1'b1;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end

                S_RUN: begin
                    if (clear_req) begin
                        state       <= S_CLEAR;
                        clr_addr    <= '0;
                        rd_x        <= '0;
                        rd_y        <= '0;
                        busy        <= 1'b1;
                        draw_ready  <= 1'b0;
                        pixel_valid <= 1'b0;
                        fetch_b     <= 1'b0;
                    end else if (pixel_advance && pixel_valid) begin
                        pixel_valid <= 1'b0;
                        fetch_a     <= 1'b1;
                        if (rd_x == LAST_X) begin
                            rd_x <= '0;
                            rd_y <= (rd_y == LAST_Y) ? '0 : rd_y + 1'b1;
                        end else begin
                            rd_x <= rd_x + 1'b1;
                        end
                    end else if (fetch_b) begin
                        pixel_valid <= 1'b1;
                        pixel_color <= color_next;
                    end
                end

                default: begin
                    state <= S_CLEAR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_framebuffer_pixel_source.sv
module tb_framebuffer_pixel_source;

    localparam int W  = 20;
    localparam int H  = 10;
    localparam int N  = W * H;
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);

    localparam logic [15:0] C_BLACK = 16'h0000;
    localparam logic [15:0] C_WHITE = 16'hFFFF;
    localparam logic [15:0] C_RED   = 16'hF800;

    logic          clk = 1'b0;
    logic          rstb;
    logic          ena;
    logic          draw_valid;
    logic          draw_ready;
    logic [XW-1:0] draw_x;
    logic [YW-1:0] draw_y;
    logic          draw_ink;
    logic          draw_err;
    logic          clear_req;
    logic          busy;
    logic          pixel_advance;
    logic          pixel_valid;
    logic [15:0]   pixel_color;

    int tests = 0;
    int fails = 0;
    bit model [N];
    int cur_x = 0;
    int cur_y = 0;
    int pos   = 0;

    always #5 clk = ~clk;

    framebuffer_pixel_source #(
        .DISPLAY_WIDTH  (W),
        .DISPLAY_HEIGHT (H)
    ) dut (
        .clk           (clk),
        .rstb          (rstb),
        .ena           (ena),
        .draw_valid    (draw_valid),
        .draw_ready    (draw_ready),
        .draw_x        (draw_x),
        .draw_y        (draw_y),
        .draw_ink      (draw_ink),
        .draw_err      (draw_err),
        .clear_req     (clear_req),
        .busy          (busy),
        .pixel_advance (pixel_advance),
        .pixel_valid   (pixel_valid),
        .pixel_color   (pixel_color)
    );

    // Expected colour of raster index p from the bench's own picture of the frame.
    function automatic logic [15:0] exp_color(input int p);
`ifdef FRAMEBUFFER_CURSOR_EN
        if ((p % W == cur_x) && (p / W == cur_y)) return C_RED;
`endif
        return model[p] ? C_WHITE : C_BLACK;
    endfunction

    task automatic do_draw(input int x, input int y, input bit ink, output bit e1, output bit e2);
        draw_x     = XW'(x);
        draw_y     = YW'(y);
        draw_ink   = ink;
        draw_valid = 1'b1;
        @(negedge clk);
        draw_valid = 1'b0;
        e1 = draw_err;
        @(negedge clk);
        e2 = draw_err;
        if (x < W && y < H) begin
            model[y * W + x] = ink;
            cur_x = x;
            cur_y = y;
        end
    endtask

    // Waits (bounded) for a valid pixel, captures it and consumes it.
    task automatic rd_adv(output logic [15:0] col, output bit ok);
        for (int i = 0; i < 16 && !pixel_valid; i++) @(negedge clk);
        ok  = pixel_valid;
        col = pixel_color;
        if (ok) begin
            pixel_advance = 1'b1;
            @(negedge clk);
            pixel_advance = 1'b0;
            pos = (pos + 1) % N;
        end
    endtask

    task automatic test_reset();
        rstb = 1'b0; ena = 1'b1; draw_valid = 1'b0; draw_x = '0; draw_y = '0;
        draw_ink = 1'b0; clear_req = 1'b0; pixel_advance = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL reset_busy got %b want 1", busy); end
        tests++; if (draw_ready !== 1'b0) begin fails++; $display("FAIL reset_draw_ready got %b want 0", draw_ready); end
        tests++; if (draw_err !== 1'b0) begin fails++; $display("FAIL reset_draw_err got %b want 0", draw_err); end
        tests++; if (pixel_valid !== 1'b0) begin fails++; $display("FAIL reset_pixel_valid got %b want 0", pixel_valid); end
        tests++; if (pixel_color !== C_BLACK) begin fails++; $display("FAIL reset_pixel_color got %h want %h", pixel_color, C_BLACK); end
    endtask

    task automatic test_initial_clear();
        int cnt = 0;
        rstb = 1'b1;
        while (busy && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        tests++; if (cnt != N) begin fails++; $display("FAIL clear_len got %0d want %0d", cnt, N); end
        tests++; if (draw_ready !== 1'b1) begin fails++; $display("FAIL run_draw_ready got %b want 1", draw_ready); end
        tests++; if (pixel_valid !== 1'b0) begin fails++; $display("FAIL first_valid_c0 got %b want 0", pixel_valid); end
        @(negedge clk);
        tests++; if (pixel_valid !== 1'b0) begin fails++; $display("FAIL first_valid_c1 got %b want 0", pixel_valid); end
        @(negedge clk);
        tests++; if (pixel_valid !== 1'b1) begin fails++; $display("FAIL first_valid_c2 got %b want 1", pixel_valid); end
        tests++; if (pixel_color !== exp_color(0)) begin fails++; $display("FAIL first_color got %h want %h", pixel_color, exp_color(0)); end
        pos = 0;
    endtask

    task automatic test_stable_under_write();
        bit e1, e2;
        logic [15:0] exp0;
        exp0 = exp_color(0);
        do_draw(0, 0, 1'b1, e1, e2);
        tests++; if (e1 !== 1'b0) begin fails++; $display("FAIL inrange_no_err got %b want 0", e1); end
        repeat (3) @(negedge clk);
        tests++; if (pixel_valid !== 1'b1 || pixel_color !== exp0) begin
            fails++; $display("FAIL stable_pixel got v=%b %h want v=1 %h", pixel_valid, pixel_color, exp0);
        end
        do_draw(0, 0, 1'b0, e1, e2);
    endtask

    task automatic test_ena_hold();
        ena = 1'b0;
        pixel_advance = 1'b1;
        repeat (3) @(negedge clk);
        pixel_advance = 1'b0;
        tests++; if (pixel_valid !== 1'b1) begin fails++; $display("FAIL ena_hold_valid got %b want 1", pixel_valid); end
        ena = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_draw_pixel();
        bit e1, e2, ok;
        logic [15:0] col;
        int p;
        do_draw(5, 0, 1'b1, e1, e2);
        tests++; if (e1 !== 1'b0) begin fails++; $display("FAIL draw5_no_err got %b want 0", e1); end
        for (int k = 0; k < 4; k++) begin
            p = pos;
            rd_adv(col, ok);
            tests++; if (!ok || col !== exp_color(p)) begin
                fails++; $display("FAIL draw_scan pos=%0d got v=%b %h want %h", p, ok, col, exp_color(p));
            end
        end
        // Pixel 4 with a two-cycle advance: the second cycle falls while pixel_valid is low.
        for (int i = 0; i < 16 && !pixel_valid; i++) @(negedge clk);
        tests++; if (pixel_valid !== 1'b1 || pixel_color !== exp_color(4)) begin
            fails++; $display("FAIL pix4 got v=%b %h want %h", pixel_valid, pixel_color, exp_color(4));
        end
        pixel_advance = 1'b1;
        @(negedge clk);
        tests++; if (pixel_valid !== 1'b0) begin fails++; $display("FAIL adv_c1 got %b want 0", pixel_valid); end
        @(negedge clk);
        pixel_advance = 1'b0;
        tests++; if (pixel_valid !== 1'b0) begin fails++; $display("FAIL adv_c2 got %b want 0", pixel_valid); end
        @(negedge clk);
        tests++; if (pixel_valid !== 1'b1) begin fails++; $display("FAIL adv_c3 got %b want 1", pixel_valid); end
        pos = 5;
        for (int k = 0; k < 2; k++) begin
            p = pos;
            rd_adv(col, ok);
            tests++; if (!ok || col !== exp_color(p)) begin
                fails++; $display("FAIL draw_scan pos=%0d got v=%b %h want %h", p, ok, col, exp_color(p));
            end
        end
    endtask

    task automatic test_draw_err();
        bit e1, e2, ok;
        logic [15:0] col;
        int p;
        do_draw(20, 3, 1'b1, e1, e2);
        tests++; if (e1 !== 1'b1 || e2 !== 1'b0) begin fails++; $display("FAIL err_x got %b%b want 10", e1, e2); end
        do_draw(7, 10, 1'b1, e1, e2);
        tests++; if (e1 !== 1'b1 || e2 !== 1'b0) begin fails++; $display("FAIL err_y got %b%b want 10", e1, e2); end
        // Full frame through the wrap back to the same position.
        for (int k = 0; k < N; k++) begin
            p = pos;
            rd_adv(col, ok);
            tests++; if (!ok || col !== exp_color(p)) begin
                fails++; $display("FAIL frame_scan pos=%0d got v=%b %h want %h", p, ok, col, exp_color(p));
            end
        end
    endtask

    task automatic test_clear_mid();
        bit ok;
        logic [15:0] col;
        int cnt = 0;
        int p;
        for (int k = 0; k < 3; k++) rd_adv(col, ok);
        clear_req = 1'b1;
        @(negedge clk);
        clear_req = 1'b0;
        tests++; if (draw_ready !== 1'b0 || pixel_valid !== 1'b0) begin
            fails++; $display("FAIL clr_outputs got rdy=%b v=%b want 0 0", draw_ready, pixel_valid);
        end
        while (busy && cnt < 1000) begin
            cnt++;
            @(negedge clk);
        end
        tests++; if (cnt != N) begin fails++; $display("FAIL clr_mid_len got %0d want %0d", cnt, N); end
        for (int i = 0; i < N; i++) model[i] = 1'b0;
        pos = 0;
        for (int k = 0; k < 7; k++) begin
            p = pos;
            rd_adv(col, ok);
            tests++; if (!ok || col !== exp_color(p)) begin
                fails++; $display("FAIL clr_scan pos=%0d got v=%b %h want %h", p, ok, col, exp_color(p));
            end
        end
    endtask

    task automatic test_cursor();
        bit e1, e2, ok;
        logic [15:0] col;
        logic [15:0] want43;
        int p;
`ifdef FRAMEBUFFER_CURSOR_EN
        want43 = C_RED;
`else
        want43 = C_BLACK;
`endif
        do_draw(3, 2, 1'b0, e1, e2);
        while (pos < 43) begin
            p = pos;
            rd_adv(col, ok);
            tests++; if (!ok || col !== exp_color(p)) begin
                fails++; $display("FAIL cur_scan pos=%0d got v=%b %h want %h", p, ok, col, exp_color(p));
            end
        end
        rd_adv(col, ok);
        tests++; if (!ok || col !== want43) begin
            fails++; $display("FAIL cursor_pix43 got v=%b %h want %h", ok, col, want43);
        end
    endtask

    initial begin
        test_reset();
        test_initial_clear();
        test_stable_under_write();
        test_ena_hold();
        test_draw_pixel();
        test_draw_err();
        test_clear_mid();
        test_cursor();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/framebuffer_pixel_source.md
FRAMEBUFFER_PIXEL_SOURCE -- requirements
Module: framebuffer_pixel_source

Interface
REQ-001 Parameter DISPLAY_WIDTH, 240, pixels per row.
REQ-002 Parameter DISPLAY_HEIGHT, 320, rows per frame.
REQ-003 Parameter FG_COLOR, WHITE, 16-bit colour for ink=1 pixels.
REQ-004 Parameter BG_COLOR, BLACK, 16-bit colour for ink=0 pixels.
REQ-005 clk  input  1  sole clock; all state on posedge clk.
REQ-006 rstb  input  1  asynchronous, active-low reset.
REQ-007 ena  input  1  clock enable; when low, all state holds.
REQ-008 draw_valid  input  1  draw request present.
REQ-009 draw_ready  output  1  draw request can be accepted.
REQ-010 draw_x  input  $clog2(DISPLAY_WIDTH)  draw column.
REQ-011 draw_y  input  $clog2(DISPLAY_HEIGHT)  draw row.
REQ-012 draw_ink  input  1  1 = set pixel, 0 = erase.
REQ-013 draw_err  output  1  one-cycle pulse, out-of-range draw dropped.
REQ-014 clear_req  input  1  pulse; erase whole frame.
REQ-015 busy  output  1  high while clearing.
REQ-016 pixel_advance  input  1  display consumed current pixel (one pulse per pixel).
REQ-017 pixel_valid  output  1  pixel_color holds the current raster pixel.
REQ-018 pixel_color  output  16  ILI9341_color_t of current raster pixel.

Function
REQ-019 Storage: 1 bit per pixel, DISPLAY_WIDTH*DISPLAY_HEIGHT entries, address = y*DISPLAY_WIDTH + x, 1-cycle synchronous read, one write and one read port per cycle.
REQ-020 FSM states: S_CLEAR, S_RUN; reset enters S_CLEAR.
REQ-021 S_CLEAR: write 0 to one address per enabled cycle, 0 to W*H-1; after last address go to S_RUN; busy=1, draw_ready=0, pixel_valid=0.
REQ-022 clear_req in S_CLEAR restarts the sweep at address 0; clear_req in S_RUN enters S_CLEAR and resets the raster position to (0,0).
REQ-023 S_RUN: draw_ready=1; draw accepted when draw_valid&draw_ready; in-range draw writes draw_ink the next cycle.
REQ-024 Draw with draw_x>=DISPLAY_WIDTH or draw_y>=DISPLAY_HEIGHT: no write, draw_err=1 the cycle after acceptance.
REQ-025 Raster counters rd_x/rd_y start at (0,0); pixel_advance with pixel_valid=1 increments rd_x, wraps to 0 at W-1 and increments rd_y, which wraps to 0 at H-1.
REQ-026 pixel_valid deasserts the cycle after an accepted pixel_advance and reasserts 2 cycles after it with the new pixel's colour; pixel_advance while pixel_valid=0 is ignored.
REQ-027 First pixel_valid after entering S_RUN occurs 2 cycles later.
REQ-028 Same-cycle write and read of one address: read returns old data (read-first).
REQ-029 pixel_color = FG_COLOR if stored bit is 1, else BG_COLOR; stable while pixel_valid=1.

Reset
REQ-030 rstb low: state=S_CLEAR, clear address 0, rd_x=rd_y=0, draw_ready=0, draw_err=0, busy=1, pixel_valid=0, pixel_color=BG_COLOR.
REQ-031 Reset mid-clear or mid-frame abandons progress; memory is fully re-cleared.

Configuration
REQ-032 Macro FRAMEBUFFER_CURSOR_EN defined: registers cursor_x/cursor_y (reset 0,0) from each accepted in-range draw; when (rd_x,rd_y)==cursor, pixel_color = CURSOR_COLOR (parameter, default RED) regardless of stored bit.
REQ-033 Macro undefined: no cursor registers; colour depends only on memory.

Structure
REQ-034 ILI9341_color_t and colour constants come from the shared ILI9341 defines; FSM state enum and address-width constant go in package framebuffer_pkg.
REQ-035 Storage is sub-module simple_dual_port_ram (W, L parameters, 1-cycle read).

Verification
REQ-036 Reset release -> busy=1 for exactly 76800 cycles, then draw_ready=1, pixel_valid=1 two cycles later with pixel_color=BLACK.
REQ-037 Draw (5,0,ink=1), advance 5 times -> sixth pixel WHITE, pixels 0-4 and 6 BLACK.
REQ-038 Draw (240,10) -> draw_err pulses once; no pixel changes over a full frame.
REQ-039 76800 advances -> raster wraps to (0,0); drawn pixel reappears at the same position.
REQ-040 clear_req at mid-frame -> busy=1 76800 cycles, raster at (0,0), previously drawn pixel now BLACK.
REQ-041 FRAMEBUFFER_CURSOR_EN: draw (3,2,ink=0) -> pixel 483 RED; without macro BLACK.
